// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipeline_pkg;

   localparam int REG_W = 5;

   localparam logic [1:0] S_RUN      = 2'd0;
   localparam logic [1:0] S_MEM_WAIT = 2'd1;
   localparam logic [1:0] S_HALT     = 2'd2;

   typedef enum logic [1:0] {
      ST_RUN      = S_RUN,
      ST_MEM_WAIT = S_MEM_WAIT,
      ST_HALT     = S_HALT
   } state_e;

   // Control word for the PC and the four inter-stage buffers.
   typedef struct packed {
      logic pc_go;
      logic if_id_go;
      logic if_id_clear;
      logic id_exe_go;
      logic id_exe_clear;
      logic exe_mem_go;
      logic exe_mem_clear;
      logic mem_wb_go;
      logic mem_wb_clear;
   } ctrl_t;

   //                                       pc IFID IDEX EXME MEWB
   localparam ctrl_t CTRL_HOLD   = 9'b0_00_00_00_00;
   localparam ctrl_t CTRL_NORM   = 9'b1_10_10_10_10;
   localparam ctrl_t CTRL_RESET  = 9'b0_11_11_11_11;
   localparam ctrl_t CTRL_MEM    = 9'b0_00_00_00_11;
   localparam ctrl_t CTRL_BRANCH = 9'b1_11_11_10_10;
   localparam ctrl_t CTRL_LDUSE  = 9'b0_00_11_10_10;

   // True when a source operand is actually read and names the given register.
   function automatic logic reg_match(input logic uses,
                                      input logic [REG_W-1:0] src,
                                      input logic [REG_W-1:0] dst);
      return uses & (src == dst);
   endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and buffer controls exchanged between the datapath and the controller.
interface pipeline_ctrl_if;
   import pipeline_pkg::*;

   logic             ex_is_load;
   logic [REG_W-1:0] ex_rd;
   logic [REG_W-1:0] id_rs;
   logic [REG_W-1:0] id_rt;
   logic             id_uses_rs;
   logic             id_uses_rt;
   logic             exe_branch_taken;
   logic             mem_req;
   logic             mem_ready;
   logic             wb_halt;
   logic             resume;

   logic             pc_go;
   logic             if_id_go;
   logic             if_id_clear;
   logic             id_exe_go;
   logic             id_exe_clear;
   logic             exe_mem_go;
   logic             exe_mem_clear;
   logic             mem_wb_go;
   logic             mem_wb_clear;

   // Datapath side: reports pipeline events, receives buffer controls.
   modport master (
      output ex_is_load, ex_rd, id_rs, id_rt, id_uses_rs, id_uses_rt,
             exe_branch_taken, mem_req, mem_ready, wb_halt, resume,
      input  pc_go, if_id_go, if_id_clear, id_exe_go, id_exe_clear,
             exe_mem_go, exe_mem_clear, mem_wb_go, mem_wb_clear
   );

   // Controller side.
   modport slave (
      input  ex_is_load, ex_rd, id_rs, id_rt, id_uses_rs, id_uses_rt,
             exe_branch_taken, mem_req, mem_ready, wb_halt, resume,
      output pc_go, if_id_go, if_id_clear, id_exe_go, id_exe_clear,
             exe_mem_go, exe_mem_clear, mem_wb_go, mem_wb_clear
   );

endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use comparator; register 0 never creates a dependency.
module hazard_detect
   import pipeline_pkg::*;
(
   input  logic             ex_is_load,
   input  logic [REG_W-1:0] ex_rd,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   output logic             load_use
);

   // Flag an ID source that depends on a load still in EXE.
   always_comb begin
      load_use = 1'b0;
      if (ex_is_load && (ex_rd != {REG_W{1'b0}})) begin
         load_use = reg_match(id_uses_rs, id_rs, ex_rd) |
                    reg_match(id_uses_rt, id_rt, ex_rd);
      end else begin
         load_use = 1'b0;
      end
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central hazard/sequencing controller: drives PC enable and inter-stage buffer
// go/clear combinationally from the registered state and current hazards.
module pipeline_ctrl
   import pipeline_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   pipeline_ctrl_if.slave   bus,
   output logic             halted,
   output logic             mem_err,
   output logic [CNT_W-1:0] cyc_cnt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  cyc_q, cyc_d;
   logic [CNT_W-1:0]  stall_q, stall_d;
   logic [CNT_W-1:0]  flush_q, flush_d;

   logic              load_use;
   logic              mem_stall;
   logic              halt_row_en;
   logic              mem_row_en;
   ctrl_t             row_ctrl;
   state_e            row_state;
   logic [WAIT_W-1:0] row_wait;
   logic              row_stall_inc;
   logic              row_flush_inc;
   ctrl_t             ctrl;

   hazard_detect u_hazard (
      .ex_is_load (bus.ex_is_load),
      .ex_rd      (bus.ex_rd),
      .id_rs      (bus.id_rs),
      .id_rt      (bus.id_rt),
      .id_uses_rs (bus.id_uses_rs),
      .id_uses_rt (bus.id_uses_rt),
      .load_use   (load_use)
   );

   assign mem_stall = bus.mem_req & ~bus.mem_ready;

   // The halt row only applies from RUN (HALT resume masks it so the syscall
   // retires); the memory row is skipped on the cycle a wait completes.
   assign halt_row_en = (state_q == ST_RUN);
   assign mem_row_en  = (state_q != ST_MEM_WAIT);

   // Evaluate the RUN priority list: halt > mem stall > branch > load-use > normal.
   always_comb begin
      row_ctrl      = CTRL_NORM;
      row_state     = ST_RUN;
      row_wait      = wait_q;
      row_stall_inc = 1'b0;
      row_flush_inc = 1'b0;
      if (halt_row_en && bus.wb_halt) begin
         row_ctrl  = CTRL_HOLD;
         row_state = ST_HALT;
      end else if (mem_row_en && mem_stall) begin
         row_ctrl      = CTRL_MEM;
         row_state     = ST_MEM_WAIT;
         row_wait      = WAIT_W'(1);
         row_stall_inc = 1'b1;
      end else if (bus.exe_branch_taken) begin
         // A load-use seen alongside a taken branch belongs to the wrong path.
         row_ctrl      = CTRL_BRANCH;
         row_flush_inc = 1'b1;
      end else if (load_use) begin
         row_ctrl      = CTRL_LDUSE;
         row_stall_inc = 1'b1;
      end else begin
         row_ctrl = CTRL_NORM;
      end
   end

   // Next-state, counter updates and buffer controls for each state.
   always_comb begin
      ctrl    = CTRL_HOLD;
      state_d = state_q;
      wait_d  = wait_q;
      err_d   = err_q;
      cyc_d   = cyc_q + CNT_W'(1);
      stall_d = stall_q;
      flush_d = flush_q;
      if (rst) begin
         // Fill every buffer with bubbles while reset is held.
         ctrl    = CTRL_RESET;
         state_d = ST_RUN;
         wait_d  = {WAIT_W{1'b0}};
         err_d   = 1'b0;
         cyc_d   = {CNT_W{1'b0}};
         stall_d = {CNT_W{1'b0}};
         flush_d = {CNT_W{1'b0}};
      end else begin
         case (state_q)
            ST_RUN: begin
               ctrl    = row_ctrl;
               state_d = row_state;
               wait_d  = row_wait;
               stall_d = stall_q + CNT_W'(row_stall_inc);
               flush_d = flush_q + CNT_W'(row_flush_inc);
            end
            ST_MEM_WAIT: begin
               if (bus.mem_ready) begin
                  ctrl    = row_ctrl;
                  state_d = row_state;
                  stall_d = stall_q + CNT_W'(row_stall_inc);
                  flush_d = flush_q + CNT_W'(row_flush_inc);
               end else begin
                  ctrl    = CTRL_MEM;
                  stall_d = stall_q + CNT_W'(1);
                  if (wait_q == WAIT_W'(MEM_TIMEOUT)) begin
                     err_d   = 1'b1;
                     state_d = ST_HALT;
                  end else begin
                     wait_d = wait_q + WAIT_W'(1);
                  end
               end
            end
            ST_HALT: begin
               // After a memory timeout only reset leaves HALT.
               if (bus.resume && !err_q) begin
                  ctrl    = row_ctrl;
                  state_d = row_state;
                  wait_d  = row_wait;
                  stall_d = stall_q + CNT_W'(row_stall_inc);
                  flush_d = flush_q + CNT_W'(row_flush_inc);
               end else begin
                  ctrl = CTRL_HOLD;
               end
            end
            default: begin
               ctrl    = CTRL_HOLD;
               state_d = ST_RUN;
            end
         endcase
      end
   end

   // State, wait counter, error flag and performance counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         wait_q  <= {WAIT_W{1'b0}};
         err_q   <= 1'b0;
         cyc_q   <= {CNT_W{1'b0}};
         stall_q <= {CNT_W{1'b0}};
         flush_q <= {CNT_W{1'b0}};
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
         cyc_q   <= cyc_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign bus.pc_go         = ctrl.pc_go;
   assign bus.if_id_go      = ctrl.if_id_go;
   assign bus.if_id_clear   = ctrl.if_id_clear;
   assign bus.id_exe_go     = ctrl.id_exe_go;
   assign bus.id_exe_clear  = ctrl.id_exe_clear;
   assign bus.exe_mem_go    = ctrl.exe_mem_go;
   assign bus.exe_mem_clear = ctrl.exe_mem_clear;
   assign bus.mem_wb_go     = ctrl.mem_wb_go;
   assign bus.mem_wb_clear  = ctrl.mem_wb_clear;

   assign halted    = (state_q == ST_HALT);
   assign mem_err   = err_q;
   assign cyc_cnt   = cyc_q;
   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: each step pushes the expected control
// word, status and counters to a scoreboard, then pops and compares mid-cycle.
module tb_pipeline_ctrl;

   localparam int CNT_W = 32;

   //                               pc IFID IDEX EXME MEWB
   localparam logic [8:0] E_HOLD = 9'b0_00_00_00_00;
   localparam logic [8:0] E_NORM = 9'b1_10_10_10_10;
   localparam logic [8:0] E_RST  = 9'b0_11_11_11_11;
   localparam logic [8:0] E_MEM  = 9'b0_00_00_00_11;
   localparam logic [8:0] E_BR   = 9'b1_11_11_10_10;
   localparam logic [8:0] E_LU   = 9'b0_00_11_10_10;

   typedef struct {
      string       tag;
      logic [8:0]  ctl;
      logic        h;
      logic        e;
      logic [31:0] cyc;
      logic [31:0] st;
      logic [31:0] fl;
   } exp_t;

   logic             clk;
   logic             rst;
   logic             halted;
   logic             mem_err;
   logic [CNT_W-1:0] cyc_cnt;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   pipeline_ctrl_if bus ();

   pipeline_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .halted    (halted),
      .mem_err   (mem_err),
      .cyc_cnt   (cyc_cnt),
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t sb[$];
   int   e_cyc   = 0;
   int   e_stall = 0;
   int   e_flush = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Drive one cycle of inputs, record expectations, compare mid-cycle, advance.
   task automatic step(input string tag, input logic r, input logic ld,
                       input logic [4:0] rd, input logic [4:0] rs,
                       input logic urs, input logic urt, input logic br,
                       input logic mq, input logic mr, input logic wh, input logic res,
                       input logic [8:0] ectl, input logic eh, input logic ee,
                       input int dst, input int dfl);
      exp_t       e;
      exp_t       x;
      logic [8:0] got;
      rst                  = r;
      bus.ex_is_load       = ld;
      bus.ex_rd            = rd;
      bus.id_rs            = rs;
      bus.id_rt            = rs;
      bus.id_uses_rs       = urs;
      bus.id_uses_rt       = urt;
      bus.exe_branch_taken = br;
      bus.mem_req          = mq;
      bus.mem_ready        = mr;
      bus.wb_halt          = wh;
      bus.resume           = res;
      e.tag = tag; e.ctl = ectl; e.h = eh; e.e = ee;
      e.cyc = 32'(e_cyc); e.st = 32'(e_stall); e.fl = 32'(e_flush);
      sb.push_back(e);
      #3;
      got = {bus.pc_go, bus.if_id_go, bus.if_id_clear, bus.id_exe_go, bus.id_exe_clear,
             bus.exe_mem_go, bus.exe_mem_clear, bus.mem_wb_go, bus.mem_wb_clear};
      x = sb.pop_front();
      chk({x.tag, ".ctl"},    32'(got),      32'(x.ctl));
      chk({x.tag, ".halted"}, 32'(halted),   32'(x.h));
      chk({x.tag, ".mem_err"},32'(mem_err),  32'(x.e));
      chk({x.tag, ".cyc"},    cyc_cnt,       x.cyc);
      chk({x.tag, ".stall"},  stall_cnt,     x.st);
      chk({x.tag, ".flush"},  flush_cnt,     x.fl);
      if (r) begin
         e_cyc = 0; e_stall = 0; e_flush = 0;
      end else begin
         e_cyc   = e_cyc + 1;
         e_stall = e_stall + dst;
         e_flush = e_flush + dfl;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      bus.ex_is_load = 1'b0; bus.ex_rd = 5'd0; bus.id_rs = 5'd0; bus.id_rt = 5'd0;
      bus.id_uses_rs = 1'b0; bus.id_uses_rt = 1'b0; bus.exe_branch_taken = 1'b0;
      bus.mem_req = 1'b0; bus.mem_ready = 1'b0; bus.wb_halt = 1'b0; bus.resume = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      //    tag          r ld rd     rs     urs urt br mq mr wh rs  ctl     h  e  dst dfl
      step("rst",        1,0,5'd0, 5'd0,  0, 0, 0, 0, 0, 0, 0, E_RST,  0, 0, 0, 0);
      step("idle",       0,0,5'd0, 5'd0,  0, 0, 0, 0, 0, 0, 0, E_NORM, 0, 0, 0, 0);
      step("lu_rs",      0,1,5'd5, 5'd5,  1, 0, 0, 0, 0, 0, 0, E_LU,   0, 0, 1, 0);
      step("idle2",      0,0,5'd0, 5'd0,  0, 0, 0, 0, 0, 0, 0, E_NORM, 0, 0, 0, 0);
      step("lu_rt",      0,1,5'd5, 5'd5,  0, 1, 0, 0, 0, 0, 0, E_LU,   0, 0, 1, 0);
      step("no_match",   0,1,5'd5, 5'd6,  1, 1, 0, 0, 0, 0, 0, E_NORM, 0, 0, 0, 0);
      step("not_load",   0,0,5'd5, 5'd5,  1, 1, 0, 0, 0, 0, 0, E_NORM, 0, 0, 0, 0);
      step("reg0",       0,1,5'd0, 5'd0,  1, 1, 0, 0, 0, 0, 0, E_NORM, 0, 0, 0, 0);
      step("br_lu",      0,1,5'd5, 5'd5,  1, 0, 1, 0, 0, 0, 0, E_BR,   0, 0, 0, 1);
      step("idle3",      0,0,5'd0, 5'd0,  0, 0, 0, 0, 0, 0, 0, E_NORM, 0, 0, 0, 0);
      // Memory wait with a branch ignored while waiting and load-use on completion.
      step("mw_enter",   0,0,5'd0, 5'd0,  0, 0, 0, 1, 0, 0, 0, E_MEM,  0, 0, 1, 0);
      step("mw_br_ign",  0,0,5'd0, 5'd0,  0, 0, 1, 1, 0, 0, 0, E_MEM,  0, 0, 1, 0);
      step("mw_wait",    0,0,5'd0, 5'd0,  0, 0, 0, 1, 0, 0, 0, E_MEM,  0, 0, 1, 0);
      step("mw_rdy_lu",  0,1,5'd7, 5'd7,  1, 0, 0, 1, 1, 0, 0, E_LU,   0, 0, 1, 0);
      step("mw_after",   0,0,5'd0, 5'd0,  0, 0, 0, 0, 0, 0, 0, E_NORM, 0, 0, 0, 0);
      step("mw2_enter",  0,0,5'd0, 5'd0,  0, 0, 0, 1, 0, 0, 0, E_MEM,  0, 0, 1, 0);
      step("mw2_rdy",    0,0,5'd0, 5'd0,  0, 0, 0, 1, 1, 0, 0, E_NORM, 0, 0, 0, 0);
      step("mw2_run",    0,0,5'd0, 5'd0,  0, 0, 0, 0, 0, 0, 0, E_NORM, 0, 0, 0, 0);
      // Halt for ten cycles, then resume with wb_halt still asserted.
      step("halt_in",    0,0,5'd0, 5'd0,  0, 0, 0, 0, 0, 1, 0, E_HOLD, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         step($sformatf("halt%0d", i), 0,0,5'd0,5'd0, 0,0,0,0,0,1,0, E_HOLD, 1, 0, 0, 0);
      end
      step("resume",     0,0,5'd0, 5'd0,  0, 0, 0, 0, 0, 1, 1, E_NORM, 1, 0, 0, 0);
      step("post_res",   0,0,5'd0, 5'd0,  0, 0, 0, 0, 0, 0, 0, E_NORM, 0, 0, 0, 0);
      // Resume straight into a memory stall.
      step("halt2_in",   0,0,5'd0, 5'd0,  0, 0, 0, 0, 0, 1, 0, E_HOLD, 0, 0, 0, 0);
      step("halt2",      0,0,5'd0, 5'd0,  0, 0, 0, 0, 0, 1, 0, E_HOLD, 1, 0, 0, 0);
      step("res_mem",    0,0,5'd0, 5'd0,  0, 0, 0, 1, 0, 1, 1, E_MEM,  1, 0, 1, 0);
      step("res_mem_rd", 0,0,5'd0, 5'd0,  0, 0, 0, 1, 1, 0, 0, E_NORM, 0, 0, 0, 0);
      // Memory timeout: entry plus four waiting cycles, then sticky HALT.
      step("to_enter",   0,0,5'd0, 5'd0,  0, 0, 0, 1, 0, 0, 0, E_MEM,  0, 0, 1, 0);
      for (int i = 1; i <= 4; i++) begin
         step($sformatf("to_w%0d", i), 0,0,5'd0,5'd0, 0,0,0,1,0,0,0, E_MEM, 0, 0, 1, 0);
      end
      step("to_halt",    0,0,5'd0, 5'd0,  0, 0, 0, 1, 0, 0, 0, E_HOLD, 1, 1, 0, 0);
      step("to_resume",  0,0,5'd0, 5'd0,  0, 0, 0, 0, 0, 0, 1, E_HOLD, 1, 1, 0, 0);
      step("to_still",   0,0,5'd0, 5'd0,  0, 0, 0, 0, 0, 0, 0, E_HOLD, 1, 1, 0, 0);
      step("to_rst",     1,0,5'd0, 5'd0,  0, 0, 0, 0, 0, 0, 0, E_RST,  1, 1, 0, 0);
      step("to_clean",   0,0,5'd0, 5'd0,  0, 0, 0, 0, 0, 0, 0, E_NORM, 0, 0, 0, 0);
      // Reset in the middle of a memory wait.
      step("ms_enter",   0,0,5'd0, 5'd0,  0, 0, 0, 1, 0, 0, 0, E_MEM,  0, 0, 1, 0);
      step("ms_wait",    0,0,5'd0, 5'd0,  0, 0, 0, 1, 0, 0, 0, E_MEM,  0, 0, 1, 0);
      step("ms_rst",     1,0,5'd0, 5'd0,  0, 0, 0, 1, 0, 0, 0, E_RST,  0, 0, 0, 0);
      step("ms_clean",   0,0,5'd0, 5'd0,  0, 0, 0, 0, 0, 0, 0, E_NORM, 0, 0, 0, 0);
      step("final",      0,0,5'd0, 5'd0,  0, 0, 0, 0, 0, 0, 0, E_NORM, 0, 0, 0, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage pipeline.
- Drives the go/clear pair of each inter-stage buffer (IF_ID, ID_EXE, EXE_MEM, MEM_WB) and the PC enable.
- Resolves load-use stalls, taken-branch flushes, multi-cycle data-memory waits and syscall halt/resume.
- Keeps performance counters for cycles, stalls and flushes.

Parameters:
- CNT_W, 32, width of each performance counter.
- MEM_TIMEOUT, 64, number of consecutive MEM_WAIT cycles after which mem_err is raised and the block halts.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- ex_is_load  in  1  instruction in EXE is a load.
- ex_rd  in  5  destination register of the EXE instruction.
- id_rs, id_rt  in  5 each  source registers of the ID instruction.
- id_uses_rs, id_uses_rt  in  1 each  ID instruction reads rs / rt.
- exe_branch_taken  in  1  EXE resolved a taken branch or jump.
- mem_req  in  1  MEM stage is accessing data memory.
- mem_ready  in  1  data memory completes this cycle.
- wb_halt  in  1  syscall-halt instruction is in WB.
- resume  in  1  single-cycle continue pulse.
- pc_go  out  1  PC register enable.
- if_id_go, if_id_clear  out  1 each  IF_ID buffer controls.
- id_exe_go, id_exe_clear  out  1 each  ID_EXE buffer controls.
- exe_mem_go, exe_mem_clear  out  1 each  EXE_MEM buffer controls.
- mem_wb_go, mem_wb_clear  out  1 each  MEM_WB buffer controls.
- halted  out  1  state is HALT.
- mem_err  out  1  sticky memory-timeout flag.
- cyc_cnt, stall_cnt, flush_cnt  out  CNT_W each  performance counters.

Behaviour:
- Buffer semantics: go=1, clear=0 latches the upstream value; go=1, clear=1 latches zeros (a bubble); go=0 holds the current value.
- All go/clear outputs and pc_go are combinational, derived from the registered state plus the current inputs. There is zero-cycle latency from hazard to control.
- Registered state: MEM_WAIT wait counter, counters, mem_err.
- States: RUN, MEM_WAIT, HALT.
- Reset (rst=1):
  - state→RUN; counters, wait counter and mem_err cleared to 0.
  - While rst=1: pc_go=0, every buffer go=1 and clear=1, so the pipeline fills with bubbles.
- Hazard terms:
  - load_use = ex_is_load & ex_rd!=0 & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
  - mem_stall = mem_req & ~mem_ready.
- Priority in RUN, highest first:
  1. wb_halt: all go=0 and pc_go=0; next state HALT.
  2. mem_stall: pc_go=0; IF_ID, ID_EXE and EXE_MEM go=0; MEM_WB go=1, clear=1 (bubble); next state MEM_WAIT; wait counter←1.
  3. exe_branch_taken: pc_go=1; IF_ID and ID_EXE go=1, clear=1; the rest normal; flush_cnt += 1. A simultaneous load_use is ignored because its instruction is wrong-path.
  4. load_use: pc_go=0; IF_ID go=0; ID_EXE go=1, clear=1; EXE_MEM and MEM_WB normal; stall_cnt += 1.
  5. Otherwise every go=1, every clear=0, pc_go=1.
- MEM_WAIT:
  - Outputs same as the RUN mem_stall row; stall_cnt += 1 each cycle, including the entry cycle.
  - exe_branch_taken and load_use are ignored while waiting. Their sources are frozen, so they re-evaluate after the wait.
  - mem_ready=1: outputs follow the RUN priority list (excluding rows 1–2) in that same cycle; next state RUN.
  - Otherwise the wait counter increments. When wait counter==MEM_TIMEOUT with no mem_ready: mem_err←1, next state HALT.
- HALT:
  - All go=0, pc_go=0, halted=1. wb_halt is ignored.
  - resume=1 and mem_err=0: outputs follow RUN rows 2–5 in that cycle (wb_halt masked so the syscall retires); next state RUN.
  - resume with mem_err=1 is ignored; only rst leaves HALT.
- Counters:
  - cyc_cnt increments every non-reset cycle, including HALT.
  - All counters wrap modulo 2^CNT_W.
- Reset asserted mid-stall or mid-halt takes effect at the next posedge regardless of state.

Decomposition:
- Package pipeline_pkg:
  - State encoding constants S_RUN=2'd0, S_MEM_WAIT=2'd1, S_HALT=2'd2.
  - Register-number width constant (5).
- Sub-module hazard_detect: purely combinational load_use comparator, reused by the forwarding unit.

Test Plan:
- Load-use: ex_is_load=1, ex_rd=5, id_rs=5, id_uses_rs=1 for one cycle → pc_go=0, if_id_go=0, id_exe_go=1 and id_exe_clear=1 in that cycle; stall_cnt 0→1.
- Branch plus load-use in the same cycle: exe_branch_taken=1 with the load-use inputs above → if_id_clear=1, id_exe_clear=1, pc_go=1; flush_cnt=1, stall_cnt=0.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 → 3 cycles with pc_go=0 and mem_wb_clear=1; stall_cnt=3; state back in RUN the cycle after mem_ready.
- Timeout: with MEM_TIMEOUT=4, hold mem_req=1, mem_ready=0 → after the 4th wait cycle mem_err=1 and halted=1; a resume pulse leaves halted=1; a 1-cycle rst clears everything.
- Halt/resume: wb_halt=1 → next cycle halted=1 and all go=0 for 10 cycles with cyc_cnt still advancing. Pulse resume with wb_halt still 1 → all go=1 that cycle; halted=0 next cycle.
- Register-0 case: ex_is_load=1, ex_rd=0, id_rs=0, id_uses_rs=1 → no stall, all go=1; stall_cnt unchanged.
